clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 128 ++++++++++++
 tb/tb_clk_div_prog.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with glitch-free registered outputs.
// Define CLK_DIV_PROG_DUTY_EN to add the cfg_high port for programmable duty cycle.
module clk_div_prog #(
    parameter int CHANNELS    = 2,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 50_000_000,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
`ifdef CLK_DIV_PROG_DUTY_EN
    input  logic [CNT_W-1:0]    cfg_high,
`endif
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic                cfg_err
);

    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TWO      = ONE << 1;
    localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_HIGH = DEF_DIV >> 1;
    localparam logic [CNT_W-1:0] DEF_CNT  = DEF_DIV - ONE;

    logic             ch_bad;
    logic             div_bad;
    logic             high_bad;
    logic             wr_bad;
    logic             wr_ok;
    logic [CNT_W-1:0] wr_high;
    logic             cfg_err_q;

    assign ch_bad  = ({1'b0, cfg_ch} >= (CH_W+1)'(CHANNELS));
    assign div_bad = (cfg_div < TWO);

`ifdef CLK_DIV_PROG_DUTY_EN
    assign wr_high  = cfg_high;
    assign high_bad = (cfg_high == '0) || (cfg_high >= cfg_div);
`else
    assign wr_high  = cfg_div >> 1;
    assign high_bad = 1'b0;
`endif

    assign wr_bad  = ch_bad || div_bad || high_bad;
    assign wr_ok   = cfg_we && !wr_bad;
    assign cfg_err = cfg_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we && wr_bad;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] high_q, high_d;
        logic [CNT_W-1:0] pdiv_q, phigh_q;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pend_q, pend_d;
        logic             clk_q, tick_q;
        logic             hit;
        logic             at_end;
        logic             bnd;

        assign hit    = wr_ok && (cfg_ch == CH_W'(g));
        assign at_end = (cnt_q >= div_q - ONE);
        // A disabled channel sits permanently on a period boundary.
        assign bnd    = !en[g] || at_end;

        always_comb begin
            div_d  = div_q;
            high_d = high_q;
            pend_d = pend_q;
            if (hit && bnd) begin
                div_d  = cfg_div;
                high_d = wr_high;
                pend_d = 1'b0;
            end else if (hit) begin
                pend_d = 1'b1;
            end else if (bnd && pend_q) begin
                div_d  = pdiv_q;
                high_d = phigh_q;
                pend_d = 1'b0;
            end
            if (!en[g]) begin
                cnt_d = div_d - ONE;
            end else if (at_end) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                div_q   <= DEF_DIV;
                high_q  <= DEF_HIGH;
                pdiv_q  <= DEF_DIV;
                phigh_q <= DEF_HIGH;
                cnt_q   <= DEF_CNT;
                pend_q  <= 1'b0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                div_q  <= div_d;
                high_q <= high_d;
                cnt_q  <= cnt_d;
                pend_q <= pend_d;
                if (hit && !bnd) begin
                    pdiv_q  <= cfg_div;
                    phigh_q <= wr_high;
                end
                clk_q  <= en[g] && (cnt_d < high_d);
                tick_q <= en[g] && (cnt_d == div_d - ONE);
            end
        end

        assign clk_out[g] = clk_q;
        assign tick[g]    = tick_q;
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized self-checking bench for clk_div_prog against a period-level model.
// Honors CLK_DIV_PROG_DUTY_EN when the design is built with it.
module tb_clk_div_prog;

    localparam int CH  = 3;
    localparam int W   = 8;
    localparam int DEF = 4;
    localparam int CHW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] en;
    logic          cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [W-1:0]  cfg_div;
`ifdef CLK_DIV_PROG_DUTY_EN
    logic [W-1:0]  cfg_high;
`endif
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic          cfg_err;

    int checks   = 0;
    int failures = 0;

    // Model: elapsed cycles within the current period, period length, high time.
    int m_pos[CH], m_len[CH], m_high[CH], m_plen[CH], m_phigh[CH];
    bit m_pend[CH];
    bit m_clk[CH], m_tick[CH];
    bit m_err;

    always #5 clk = ~clk;

    clk_div_prog #(
        .CHANNELS(CH),
        .CNT_W(W),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
`ifdef CLK_DIV_PROG_DUTY_EN
        .cfg_high(cfg_high),
`endif
        .clk_out(clk_out),
        .tick(tick),
        .cfg_err(cfg_err)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < CH; i++) begin
            m_len[i]  = DEF;
            m_high[i] = DEF / 2;
            m_pos[i]  = DEF - 1;
            m_pend[i] = 1'b0;
            m_clk[i]  = 1'b0;
            m_tick[i] = 1'b0;
        end
        m_err = 1'b0;
    endfunction

    function automatic void m_step();
        int wd, wh, wc;
        bit bad, edge_of_period;
        wd = int'(cfg_div);
        wc = int'(cfg_ch);
`ifdef CLK_DIV_PROG_DUTY_EN
        wh  = int'(cfg_high);
        bad = (wd < 2) || (wc >= CH) || (wh == 0) || (wh >= wd);
`else
        wh  = wd / 2;
        bad = (wd < 2) || (wc >= CH);
`endif
        m_err = cfg_we && bad;
        for (int i = 0; i < CH; i++) begin
            edge_of_period = !en[i] || (m_pos[i] == m_len[i] - 1);
            if (cfg_we && !bad && wc == i) begin
                if (edge_of_period) begin
                    m_len[i] = wd; m_high[i] = wh; m_pend[i] = 1'b0;
                end else begin
                    m_plen[i] = wd; m_phigh[i] = wh; m_pend[i] = 1'b1;
                end
            end else if (edge_of_period && m_pend[i]) begin
                m_len[i] = m_plen[i]; m_high[i] = m_phigh[i]; m_pend[i] = 1'b0;
            end
            if (!en[i]) m_pos[i] = m_len[i] - 1;
            else if (edge_of_period) m_pos[i] = 0;
            else m_pos[i] = m_pos[i] + 1;
            m_clk[i]  = en[i] && (m_pos[i] < m_high[i]);
            m_tick[i] = en[i] && (m_pos[i] == m_len[i] - 1);
        end
    endfunction

    task automatic cycle();
        m_step();
        @(negedge clk);
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("clk_out[%0d]", i), int'(clk_out[i]), int'(m_clk[i]));
            chk($sformatf("tick[%0d]", i), int'(tick[i]), int'(m_tick[i]));
        end
        chk("cfg_err", int'(cfg_err), int'(m_err));
        cfg_we = 1'b0;
    endtask

    task automatic write(input int ch, input int dv, input int hi);
        cfg_we  = 1'b1;
        cfg_ch  = CHW'(ch);
        cfg_div = W'(dv);
`ifdef CLK_DIV_PROG_DUTY_EN
        cfg_high = W'(hi);
`else
        if (hi < 0) $display("bad high argument");
`endif
    endtask

    task automatic wait_pos(input int ch, input int target);
        for (int n = 0; n < 400 && m_pos[ch] != target; n++) cycle();
        chk("wait_pos", m_pos[ch], target);
    endtask

    initial begin
        rst = 1'b1; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
`ifdef CLK_DIV_PROG_DUTY_EN
        cfg_high = '0;
`endif
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        rst = 1'b0;

        // Default divisor of 4: 1,1,0,0 with tick in the fourth cycle.
        en = 3'b001;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("dflt_clk", int'(clk_out[0]), int'((k % 4) < 2));
            chk("dflt_tick", int'(tick[0]), int'((k % 4) == 3));
        end

        // Mid-period write takes effect after the current period.
        wait_pos(0, 1);
        write(0, 6, 3);
        repeat (20) cycle();

        // Write on the last cycle bypasses pending; channel 1 keeps running.
        en = 3'b011;
        repeat (3) cycle();
        wait_pos(0, m_len[0] - 1);
        write(0, 5, 2);
        repeat (16) cycle();

        // Rejected writes: divisor too small, channel out of range.
        write(0, 1, 0);
        cycle();
        chk("err_div", int'(cfg_err), 1);
        write(3, 6, 3);
        cycle();
        chk("err_ch", int'(cfg_err), 1);
        repeat (6) cycle();

`ifdef CLK_DIV_PROG_DUTY_EN
        wait_pos(0, 2);
        write(0, 10, 3);
        repeat (25) cycle();
        write(0, 10, 10);
        cycle();
        chk("err_high", int'(cfg_err), 1);
        repeat (12) cycle();
`endif

        // Reset mid-period discards a pending write.
        wait_pos(0, 0);
        write(0, 9, 4);
        cycle();
        rst = 1'b1;
        #1;
        chk("arst_clk_out", int'(clk_out), 0);
        chk("arst_tick", int'(tick), 0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) cycle();

        // Largest divisor representable.
        wait_pos(1, m_len[1] - 1);
        write(1, 255, 127);
        repeat (300) cycle();

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 99) < 4) en[i] = ~en[i];
            if ($urandom_range(0, 99) < 25) begin
                int r, dv;
                r = $urandom_range(0, 99);
                if (r < 75) dv = $urandom_range(2, 9);
                else if (r < 90) dv = $urandom_range(0, 1);
                else dv = $urandom_range(10, 40);
                write($urandom_range(0, 3), dv, $urandom_range(0, dv));
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
